// File: rtl/rsa_engine_scheduler_pkg.sv
// Shared widths, state encoding and job bundle for the RSA engine scheduler.
// Imported by the scheduler top and its arbiter.
package rsa_pkg;

  localparam int M_W   = 8;
  localparam int E_W   = 8;
  localparam int N_W   = 16;
  localparam int C_W   = 16;
  localparam int CNT_W = 16;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_PAD   = 3'd3;
  localparam logic [2:0] ST_RESP  = 3'd4;

  typedef struct packed {
    logic [M_W-1:0] m;
    logic [E_W-1:0] e;
    logic [N_W-1:0] n;
  } job_t;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/rsa_engine_scheduler_arb.sv
// Round-robin arbiter: first set request at or above ptr, with wrap.
// Purely combinational; one-hot grant plus binary id.
module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int ID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] gnt,
  output logic [ID_W-1:0] id,
  output logic            any
);

  logic [ID_W-1:0] idx;

  always_comb begin
    gnt = '0;
    id  = '0;
    any = 1'b0;
    idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = ID_W'((int'(ptr) + i) % NREQ);
      if (!any && req[idx]) begin
        any      = 1'b1;
        id       = idx;
        gnt[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rsa_engine_scheduler.sv
// Shares one RSA engine between NREQ requesters with round-robin grant,
// optional constant-latency padding and a watchdog that resets a hung engine.
module rsa_engine_scheduler
  import rsa_pkg::*;
#(
  parameter  int NREQ      = 4,
  parameter  int CONST_LAT = 0,
  parameter  int TIMEOUT   = 4096,
  localparam int ID_W      = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [M_W*NREQ-1:0] req_m,
  input  logic [E_W*NREQ-1:0] req_e,
  input  logic [N_W*NREQ-1:0] req_n,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ID_W-1:0]   rsp_id,
  output logic [C_W-1:0]    rsp_c,
  output logic              rsp_err,
  output logic              rsp_overrun,
  output logic              busy,
  output logic              eng_rst_n,
  output logic              eng_start,
  output logic [M_W-1:0]    eng_m,
  output logic [E_W-1:0]    eng_e,
  output logic [N_W-1:0]    eng_n,
  input  logic [C_W-1:0]    eng_c,
  input  logic              eng_finish
);

  localparam bit HAS_PAD = (CONST_LAT != 0);
  localparam logic [CNT_W:0] LAT_C = (CNT_W+1)'(CONST_LAT);
  localparam logic [CNT_W:0] TO_C  = (CNT_W+1)'(TIMEOUT);
  localparam logic [CNT_W:0] PAD_END = LAT_C - 1'b1;

  logic [2:0]       state_q, state_d;
  logic [ID_W-1:0]  rr_q, rr_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  job_t             job_q, job_d;
  logic [C_W-1:0]   c_q, c_d;
  logic             err_q, err_d;
  logic             ovr_q, ovr_d;
  logic             abort_q, abort_d;

  logic [NREQ-1:0]  gnt;
  logic [ID_W-1:0]  gnt_id;
  logic             gnt_any;
  logic [CNT_W:0]   elapsed;
  logic [CNT_W:0]   elapsed_p1;
  logic             live;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req (req_valid),
    .ptr (rr_q),
    .gnt (gnt),
    .id  (gnt_id),
    .any (gnt_any)
  );

  // Cycles since the eng_start cycle, as seen in the current cycle.
  assign elapsed    = {1'b0, cnt_q} + 1'b1;
  assign elapsed_p1 = elapsed + 1'b1;

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    job_d   = job_q;
    c_d     = c_q;
    err_d   = err_q;
    ovr_d   = ovr_q;
    abort_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (gnt_any) begin
          job_d.m = req_m[int'(gnt_id)*M_W +: M_W];
          job_d.e = req_e[int'(gnt_id)*E_W +: E_W];
          job_d.n = req_n[int'(gnt_id)*N_W +: N_W];
          id_d    = gnt_id;
          c_d     = '0;
          err_d   = 1'b0;
          ovr_d   = 1'b0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = sat_inc(cnt_q);
        if (eng_finish) begin
          c_d   = eng_c;
          ovr_d = HAS_PAD && (elapsed_p1 > LAT_C);
          if (!HAS_PAD || elapsed_p1 >= LAT_C) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_PAD;
          end
        end else if (elapsed >= TO_C) begin
          c_d     = '0;
          err_d   = 1'b1;
          abort_d = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_PAD: begin
        cnt_d = sat_inc(cnt_q);
        if (elapsed >= PAD_END) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rr_d    = (id_q == ID_W'(NREQ-1)) ? '0 : id_q + 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rr_q    <= '0;
      id_q    <= '0;
      cnt_q   <= '0;
      job_q   <= '0;
      c_q     <= '0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      job_q   <= job_d;
      c_q     <= c_d;
      err_q   <= err_d;
      ovr_q   <= ovr_d;
      abort_q <= abort_d;
    end
  end

  // Outputs are forced quiet while rst is high, before the flops clear.
  assign live        = ~rst;
  assign busy        = live & (state_q != ST_IDLE);
  assign req_ready   = (live && state_q == ST_IDLE) ? gnt : '0;
  assign eng_start   = live & (state_q == ST_ISSUE);
  assign eng_m       = live ? job_q.m : '0;
  assign eng_e       = live ? job_q.e : '0;
  assign eng_n       = live ? job_q.n : '0;
  assign eng_rst_n   = ~(rst | abort_q);
  assign rsp_valid   = live & (state_q == ST_RESP);
  assign rsp_id      = rsp_valid ? id_q : '0;
  assign rsp_c       = rsp_valid ? c_q : '0;
  assign rsp_err     = rsp_valid & err_q;
  assign rsp_overrun = rsp_valid & ovr_q;

endmodule

// File: tb/tb_rsa_engine_scheduler.sv
// Directed bench: unpadded instance (TIMEOUT=50) and padded instance
// (CONST_LAT=40), each driving a behavioural engine with latency e+2.
module tb_rsa_engine_scheduler;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] modexp(input logic [7:0] m,
                                         input logic [7:0] e,
                                         input logic [15:0] n);
    logic [31:0] r;
    r = 32'd1 % {16'd0, n};
    for (int i = 0; i < int'(e); i++) r = (r * {24'd0, m}) % {16'd0, n};
    return r[15:0];
  endfunction

  // Instance A: NREQ=4, no padding, TIMEOUT=50
  logic [3:0]  a_valid, a_ready;
  logic [31:0] a_m, a_e;
  logic [63:0] a_n;
  logic        a_rsp_valid, a_rsp_ready, a_err, a_ovr, a_busy;
  logic [1:0]  a_rsp_id;
  logic [15:0] a_rsp_c, a_en;
  logic        a_ernst, a_start, a_spur, a_hang;
  logic [7:0]  a_em, a_ee;
  logic [7:0]  op_m[4];
  logic [7:0]  op_e[4];
  logic [15:0] op_n[4];
  logic [15:0] a_ec = '0;
  logic        a_fin = 1'b0;
  logic        a_act = 1'b0;
  int          a_rem = 0;

  always_comb begin
    a_m = '0;
    a_e = '0;
    a_n = '0;
    for (int i = 0; i < 4; i++) begin
      a_m[i*8 +: 8]   = op_m[i];
      a_e[i*8 +: 8]   = op_e[i];
      a_n[i*16 +: 16] = op_n[i];
    end
  end

  always @(posedge clk) begin
    a_fin <= 1'b0;
    if (!a_ernst) a_act <= 1'b0;
    else if (a_start) begin
      a_act <= !a_hang;
      a_rem <= int'(a_ee) + 1;
      a_ec  <= modexp(a_em, a_ee, a_en);
    end else if (a_act) begin
      if (a_rem == 1) begin
        a_fin <= 1'b1;
        a_act <= 1'b0;
      end else a_rem <= a_rem - 1;
    end
  end

  rsa_engine_scheduler #(.NREQ(4), .CONST_LAT(0), .TIMEOUT(50)) dut_a (
    .clk(clk), .rst(rst),
    .req_valid(a_valid), .req_ready(a_ready),
    .req_m(a_m), .req_e(a_e), .req_n(a_n),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
    .rsp_id(a_rsp_id), .rsp_c(a_rsp_c), .rsp_err(a_err),
    .rsp_overrun(a_ovr), .busy(a_busy), .eng_rst_n(a_ernst),
    .eng_start(a_start), .eng_m(a_em), .eng_e(a_ee), .eng_n(a_en),
    .eng_c(a_ec), .eng_finish(a_fin | a_spur)
  );

  // Instance B: NREQ=2, CONST_LAT=40
  logic [1:0]  b_valid, b_ready;
  logic [15:0] b_m, b_e;
  logic [31:0] b_n;
  logic        b_rsp_valid, b_rsp_ready, b_err, b_ovr, b_busy;
  logic [0:0]  b_rsp_id;
  logic [15:0] b_rsp_c, b_en;
  logic        b_ernst, b_start;
  logic [7:0]  b_em, b_ee;
  logic [15:0] b_ec = '0;
  logic        b_fin = 1'b0;
  logic        b_act = 1'b0;
  int          b_rem = 0;

  always @(posedge clk) begin
    b_fin <= 1'b0;
    if (!b_ernst) b_act <= 1'b0;
    else if (b_start) begin
      b_act <= 1'b1;
      b_rem <= int'(b_ee) + 1;
      b_ec  <= modexp(b_em, b_ee, b_en);
    end else if (b_act) begin
      if (b_rem == 1) begin
        b_fin <= 1'b1;
        b_act <= 1'b0;
      end else b_rem <= b_rem - 1;
    end
  end

  rsa_engine_scheduler #(.NREQ(2), .CONST_LAT(40), .TIMEOUT(4096)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(b_valid), .req_ready(b_ready),
    .req_m(b_m), .req_e(b_e), .req_n(b_n),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
    .rsp_id(b_rsp_id), .rsp_c(b_rsp_c), .rsp_err(b_err),
    .rsp_overrun(b_ovr), .busy(b_busy), .eng_rst_n(b_ernst),
    .eng_start(b_start), .eng_m(b_em), .eng_e(b_ee), .eng_n(b_en),
    .eng_c(b_ec), .eng_finish(b_fin)
  );

  task automatic set_op(input int i, input logic [7:0] m,
                        input logic [7:0] e, input logic [15:0] n);
    op_m[i] = m;
    op_e[i] = e;
    op_n[i] = n;
  endtask

  task automatic serve_a(input int id, input bit keep, input bit exp_err,
                         input int bp, input int exp_lat,
                         input logic [15:0] exp_c);
    int w, rn_low, bad;
    logic [15:0] c0;
    logic [1:0]  id0;
    logic        e0;
    w = 0;
    rn_low = 0;
    bad = 0;
    #1;
    while (a_ready == 4'b0 && w < 200) begin
      @(negedge clk);
      #1;
      w++;
    end
    chk("grant", a_ready, 64'd1 << id);
    @(negedge clk);
    if (!keep) a_valid[id] = 1'b0;
    chk("eng_start", a_start, 1);
    chk("eng_m", a_em, op_m[id]);
    chk("eng_e", a_ee, op_e[id]);
    chk("eng_n", a_en, op_n[id]);
    w = 0;
    while (!a_rsp_valid && w < 200) begin
      @(negedge clk);
      w++;
      if (!a_ernst) rn_low++;
      if (a_ready != 4'b0 || a_start) bad++;
    end
    chk("latency", w, exp_lat);
    chk("rsp_id", a_rsp_id, id);
    chk("rsp_c", a_rsp_c, exp_c);
    chk("rsp_err", a_err, exp_err);
    chk("rst_pulse", rn_low, exp_err);
    c0  = a_rsp_c;
    id0 = a_rsp_id;
    e0  = a_err;
    repeat (bp) begin
      @(negedge clk);
      if (!a_rsp_valid || a_rsp_c != c0 || a_rsp_id != id0 ||
          a_err != e0 || a_ready != 4'b0 || a_start) bad++;
    end
    a_rsp_ready = 1'b1;
    @(negedge clk);
    a_rsp_ready = 1'b0;
    chk("quiet_while_busy", bad, 0);
    chk("idle_after", a_busy, 0);
    chk("rsp_drop", a_rsp_valid, 0);
  endtask

  task automatic serve_b(input int id, input logic [7:0] e,
                         input int exp_lat, input bit exp_ovr);
    int w;
    b_e[id*8 +: 8] = e;
    b_valid[id] = 1'b1;
    #1;
    w = 0;
    while (b_ready == 2'b0 && w < 200) begin
      @(negedge clk);
      #1;
      w++;
    end
    chk("b_grant", b_ready, 64'd1 << id);
    @(negedge clk);
    b_valid[id] = 1'b0;
    chk("b_start", b_start, 1);
    w = 0;
    while (!b_rsp_valid && w < 300) begin
      @(negedge clk);
      w++;
    end
    chk("b_latency", w, exp_lat);
    chk("b_overrun", b_ovr, exp_ovr);
    chk("b_rsp_c", b_rsp_c, modexp(8'd89, e, 16'd3127));
    chk("b_rsp_id", b_rsp_id, id);
    chk("b_rsp_err", b_err, 0);
    b_rsp_ready = 1'b1;
    @(negedge clk);
    b_rsp_ready = 1'b0;
    chk("b_idle_after", b_busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int bad;
    rst = 1'b1;
    a_valid = '0; a_rsp_ready = 1'b0; a_spur = 1'b0; a_hang = 1'b0;
    b_valid = '0; b_rsp_ready = 1'b0;
    b_m = {2{8'd89}}; b_e = '0; b_n = {2{16'd3127}};
    for (int i = 0; i < 4; i++) set_op(i, 8'd0, 8'd0, 16'd0);
    repeat (2) @(negedge clk);
    #1;
    chk("reset_outs", {a_ready, a_rsp_valid, a_busy, a_start, a_ernst,
                       a_rsp_c, a_rsp_id, a_err, a_ovr, a_em, a_ee, a_en}, 0);
    chk("b_reset_eng_rst_n", b_ernst, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("eng_rst_n_release", a_ernst, 1);

    // Single request from requester 1
    set_op(1, 8'd89, 8'd3, 16'd3127);
    a_valid = 4'b0010;
    serve_a(1, 0, 0, 0, 6, 16'd1394);

    // Spurious finish while idle
    a_spur = 1'b1;
    @(negedge clk);
    a_spur = 1'b0;
    @(negedge clk);
    chk("spur_busy", a_busy, 0);
    chk("spur_rsp", a_rsp_valid, 0);

    // Contention from reset: 0,1,2,3 then 0 again
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    set_op(0, 8'd65, 8'd5, 16'd3233);
    set_op(1, 8'd42, 8'd7, 16'd2773);
    set_op(2, 8'd123, 8'd4, 16'd1147);
    set_op(3, 8'd7, 8'd9, 16'd187);
    a_valid = 4'b1111;
    serve_a(0, 1, 0, 0, 8,  modexp(8'd65, 8'd5, 16'd3233));
    serve_a(1, 0, 0, 0, 10, modexp(8'd42, 8'd7, 16'd2773));
    serve_a(2, 0, 0, 0, 7,  modexp(8'd123, 8'd4, 16'd1147));
    serve_a(3, 0, 0, 0, 12, modexp(8'd7, 8'd9, 16'd187));
    serve_a(0, 0, 0, 0, 8,  modexp(8'd65, 8'd5, 16'd3233));

    // Backpressure with a competing requester pending
    set_op(2, 8'd17, 8'd6, 16'd391);
    a_valid = 4'b0101;
    serve_a(2, 0, 0, 30, 9, modexp(8'd17, 8'd6, 16'd391));
    serve_a(0, 0, 0, 0, 8,  modexp(8'd65, 8'd5, 16'd3233));

    // Hung engine, then normal service
    a_hang = 1'b1;
    set_op(1, 8'd5, 8'd7, 16'd221);
    a_valid = 4'b0010;
    serve_a(1, 0, 1, 0, 51, 16'd0);
    a_hang = 1'b0;
    a_valid = 4'b0100;
    serve_a(2, 0, 0, 0, 9, modexp(8'd17, 8'd6, 16'd391));

    // Reset in the middle of WAIT
    a_valid = 4'b0100;
    #1;
    chk("midrst_grant", a_ready, 4'b0100);
    @(negedge clk);
    a_valid = 4'b0000;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_outs", {a_ready, a_rsp_valid, a_busy, a_start, a_ernst,
                        a_rsp_c, a_rsp_id, a_err, a_ovr, a_em, a_ee, a_en}, 0);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (a_rsp_valid || a_busy) bad++;
    end
    chk("midrst_no_rsp", bad, 0);
    a_valid = 4'b1001;
    serve_a(0, 0, 0, 0, 8,  modexp(8'd65, 8'd5, 16'd3233));
    serve_a(3, 0, 0, 0, 12, modexp(8'd7, 8'd9, 16'd187));

    // Padded instance, CONST_LAT=40, engine latency e+2
    serve_b(0, 8'd3,  40, 0);
    serve_b(1, 8'd30, 40, 0);
    serve_b(0, 8'd37, 40, 0);
    serve_b(1, 8'd38, 41, 1);
    serve_b(0, 8'd60, 63, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
